filter_median_stream: RTL
=========================

FILTER_MEDIAN_STREAM -- requirements
Module: filter_median_stream

Interface
REQ-001 Parameter BIT, default 8: sample width in bits, 1..16.
REQ-002 Parameter WIN, default 9: window length; odd only, 3..9.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  pixel qualifier; sample accepted on any clk edge where in_valid=1.
REQ-006 pixel  input  BIT  sample data.
REQ-007 mode  input  2  operation select, captured together with the sample: 0 median, 1 min, 2 max, 3 bypass.
REQ-008 flush  input  1  synchronous window restart.
REQ-009 out_valid  output  1  result qualifier.
REQ-010 median  output  BIT  selected result; registered output.

Function
REQ-011 Window: shift register of the last WIN accepted samples; each accepted sample shifts in as the newest entry and drops the oldest; no shift when in_valid=0.
REQ-012 Fill counter: counts accepted samples and saturates at WIN; it is the only gate on output validity.
REQ-013 Rank of entry i: number of entries j with w[j]<w[i], or with w[j]==w[i] and j<i; ranks therefore form a permutation of 0..WIN-1, including when values tie.
REQ-014 Selected rank: mode 0 -> (WIN-1)/2; mode 1 -> 0; mode 2 -> WIN-1. Output is the entry holding that rank.
REQ-015 Mode 3 (bypass): output is the newest sample; the fill gating of REQ-012 still applies.
REQ-016 Pipeline: stage 1 updates the window and fill counter; stage 2 registers all WIN ranks plus the window copy and mode; stage 3 registers median and out_valid.
REQ-017 Latency: exactly 2 clk cycles from the edge that accepts a sample to the edge that presents its result; out_valid is high for 1 cycle per qualifying sample.
REQ-018 Qualifying sample: an accepted sample that brings the fill count to WIN, or any accepted sample after that point; earlier samples produce out_valid=0.
REQ-019 Gaps: in_valid=0 cycles insert bubbles only; the window, the fill count and in-flight results are preserved.
REQ-020 mode is pipelined with its sample; a mode change affects only samples accepted on or after the change.
REQ-021 median holds its last value while out_valid=0.
REQ-022 Comparisons are unsigned over BIT bits; no arithmetic overflow paths exist.
REQ-023 flush=1: clears the window to 0, the fill count to 0 and all pipeline valid bits on that edge; a sample presented with in_valid=1 in the same cycle is discarded.
REQ-024 After a flush, the first valid result requires WIN new accepted samples.
REQ-025 There is no backpressure: the block accepts one sample per cycle sustained, and throughput is 1 result per cycle.

Reset
REQ-026 rst=1 on an edge: the window, fill count, pipeline registers, out_valid and median all go to 0.
REQ-027 rst takes priority over flush and in_valid; reset mid-stream discards all in-flight results, and out_valid is 0 on the next 2 edges after rst is released.
REQ-028 Outputs are deterministic immediately after reset; no uninitialised registers drive median.

Verification (WIN=9, BIT=8 unless stated)
REQ-029 Send ramp 0..8 back-to-back in mode 0 -> out_valid=1 for exactly 1 cycle, 2 cycles after sample 8, with median=4; out_valid=0 for samples 0..7.
REQ-030 Send ties 0,0,0,1,1,1,2,2,2 in mode 0 -> median=1; then send 9 more samples in mode 1 and in mode 2 -> min=0, max=2 on the window that ends with those values.
REQ-031 Send random samples with in_valid toggling 1/0 -> each result matches a software sort of the last 9 accepted samples; no out_valid during the gaps beyond the fixed latency.
REQ-032 Send 5 samples, assert flush together with in_valid, then send 9 samples 10..18 -> the first out_valid follows the 9th post-flush sample, median=14; the sample presented with flush does not affect any result.
REQ-033 Assert rst after 12 samples while results are in flight -> out_valid=0 and median=0 on the next edge; the stream resumes only after 9 new samples.
REQ-034 WIN=3, BIT=4: stream 15,0,7,3 in mode 0 -> results 7 then 3; in mode 3 the same stream gives 7 then 3 (newest sample), both starting at the 3rd sample.

Source files
------------

// File: rtl/filter_median_stream.sv
// Streaming rank filter: median/min/max/bypass over the last WIN accepted samples.
// Three-stage pipeline: window update, rank computation, result selection.
module filter_median_stream #(
  parameter int BIT = 8,
  parameter int WIN = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [BIT-1:0] pixel,
  input  logic [1:0]     mode,
  input  logic           flush,
  output logic           out_valid,
  output logic [BIT-1:0] median
);

  localparam int RW = $clog2(WIN);
  localparam int FW = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    MODE_MEDIAN = 2'd0,
    MODE_MIN    = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_t;

  logic [BIT-1:0] win    [WIN];
  logic [FW-1:0]  fill;
  logic           s1_valid;
  mode_t          s1_mode;

  logic [RW-1:0]  rank_c [WIN];
  logic [RW-1:0]  rank_q [WIN];
  logic [BIT-1:0] win_q  [WIN];
  logic           s2_valid;
  mode_t          s2_mode;

  logic [RW-1:0]  target;
  logic [BIT-1:0] sel;

  // Stage 1: window shift register (win[0] is newest) and saturating fill count.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: the window is a small register array, so clearing it in a loop is cheap and keeps outputs deterministic.
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      fill     <= '0;
      s1_valid <= 1'b0;
      s1_mode  <= MODE_MEDIAN;
    end else begin
      s1_valid <= in_valid && (fill >= FW'(WIN - 1));
      if (in_valid) begin
        win[0] <= pixel;
        for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
        if (fill != FW'(WIN)) fill <= fill + FW'(1);
        s1_mode <= mode_t'(mode);
      end
    end
  end

  // Tie-break on index so ranks stay a permutation even with equal values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    for (int i = 0; i < WIN; i++) begin
      rank_c[i] = '0;
      for (int j = 0; j < WIN; j++) begin
        if ((win[j] < win[i]) || ((win[j] == win[i]) && (j < i)))
          rank_c[i] = rank_c[i] + RW'(1);
      end
    end
  end

  // Stage 2: ranks, window copy and mode travel together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) begin
        rank_q[i] <= '0;
        win_q[i]  <= '0;
      end
      s2_valid <= 1'b0;
      s2_mode  <= MODE_MEDIAN;
    end else begin
      s2_valid <= s1_valid && !flush;
      rank_q   <= rank_c;
      win_q    <= win;
      s2_mode  <= s1_mode;
    end
  end

  always_comb begin
    target = RW'((WIN - 1) / 2);
    unique case (s2_mode)
      MODE_MIN: target = '0;
      MODE_MAX: target = RW'(WIN - 1);
      default:  target = RW'((WIN - 1) / 2);
    endcase
    sel = '0;
    if (s2_mode == MODE_BYPASS) begin
      sel = win_q[0];
    end else begin
      for (int i = 0; i < WIN; i++)
        if (rank_q[i] == target) sel = win_q[i];
    end
  end

  // Stage 3: registered result; median holds while no result is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      median    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) median <= sel;
    end
  end

endmodule
